// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and MDU sequencing controller for the
// five-stage core. It sits beside the D/E pipeline register. It freezes PC
// and the D register, and bubbles E, on two conditions: a read-after-write
// hazard that forwarding cannot cover, or a D-stage HI/LO/MDU user while
// the multiply/divide unit is still busy.
//
// Parameters
//   MULT_LAT  busy cycles after a mult/multu start (must be <= 15)
//   DIV_LAT   busy cycles after a div/divu start   (must be <= 15)
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   Drs, Drt                   source register fields of the D instruction
//   DTuse_rs, DTuse_rt         cycles until D needs rs/rt (3 = not used)
//   D_isMD                     D instruction uses HI/LO/MDU
//   E_RegWrite/RegSelected/Tnew  E-stage producer
//   M_RegWrite/RegSelected/Tnew  M-stage producer
//   E_mdStart, E_mdIsDiv       MDU operation starting in E (div when set)
//   stall, Ereset              freeze PC/D, flush E (identical)
//   md_busy, md_cnt            MDU busy flag and remaining busy cycles
//   stall_cnt                  stalled cycles since reset (wraps)
module hazard_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Drs,
  input  logic [4:0]  Drt,
  input  logic [1:0]  DTuse_rs,
  input  logic [1:0]  DTuse_rt,
  input  logic        D_isMD,
  input  logic        E_RegWrite,
  input  logic [4:0]  E_RegSelected,
  input  logic [3:0]  E_Tnew,
  input  logic        M_RegWrite,
  input  logic [4:0]  M_RegSelected,
  input  logic [3:0]  M_Tnew,
  input  logic        E_mdStart,
  input  logic        E_mdIsDiv,
  output logic        stall,
  output logic        Ereset,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t  state, state_next;
  logic [3:0] md_cnt_next;
  logic [3:0] load_cnt;
  logic       rs_hazard, rt_hazard, md_hazard;

  // One producer/consumer pair: the producer's result is not forwardable
  // before the consumer needs it. DTuse = 3 marks an unused operand.
  function automatic logic src_hazard(
    input logic [4:0] dreg,
    input logic [1:0] tuse,
    input logic       we,
    input logic [4:0] dst,
    input logic [3:0] tnew
  );
    return we && (dst == dreg) && (dreg != 5'd0) && (tuse != 2'd3) &&
           ({2'b00, tuse} < tnew);
  endfunction

  always_comb begin
    rs_hazard = src_hazard(Drs, DTuse_rs, E_RegWrite, E_RegSelected, E_Tnew) ||
                src_hazard(Drs, DTuse_rs, M_RegWrite, M_RegSelected, M_Tnew);
    rt_hazard = src_hazard(Drt, DTuse_rt, E_RegWrite, E_RegSelected, E_Tnew) ||
                src_hazard(Drt, DTuse_rt, M_RegWrite, M_RegSelected, M_Tnew);
  end

  // BUSY is held exactly while md_cnt != 0, so the state stands in for the
  // counter-nonzero test.
  assign md_busy   = E_mdStart | (state == BUSY);
  assign md_hazard = D_isMD & md_busy;
  assign stall     = rs_hazard | rt_hazard | md_hazard;
  assign Ereset    = stall;

  assign load_cnt  = E_mdIsDiv ? DIV_CNT : MULT_CNT;

  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    if (E_mdStart) begin
      // A start always (re)loads; any operation in flight is abandoned.
      md_cnt_next = load_cnt;
      state_next  = (load_cnt != '0) ? BUSY : IDLE;
    end else begin
      case (state)
        BUSY: begin
          md_cnt_next = md_cnt - 4'd1;
          if (md_cnt == 4'd1) state_next = IDLE;
        end
        default: begin
          md_cnt_next = '0;
          state_next  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Drs, Drt;
  logic [1:0]  DTuse_rs, DTuse_rt;
  logic        D_isMD;
  logic        E_RegWrite, M_RegWrite;
  logic [4:0]  E_RegSelected, M_RegSelected;
  logic [3:0]  E_Tnew, M_Tnew;
  logic        E_mdStart, E_mdIsDiv;
  logic        stall, Ereset, md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .Drs(Drs), .Drt(Drt), .DTuse_rs(DTuse_rs), .DTuse_rt(DTuse_rt),
    .D_isMD(D_isMD),
    .E_RegWrite(E_RegWrite), .E_RegSelected(E_RegSelected), .E_Tnew(E_Tnew),
    .M_RegWrite(M_RegWrite), .M_RegSelected(M_RegSelected), .M_Tnew(M_Tnew),
    .E_mdStart(E_mdStart), .E_mdIsDiv(E_mdIsDiv),
    .stall(stall), .Ereset(Ereset), .md_busy(md_busy), .md_cnt(md_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  // Reference model: the MDU is described by the absolute cycle at which
  // its result becomes available; the stall counter is a plain tally.
  int          cyc = 0;
  int          done_at = 0;
  int unsigned m_scnt = 0;

  function automatic bit hz(bit we, int dst, int tnew, int dreg, int tuse);
    return we && dst == dreg && dreg != 0 && tuse != 3 && tuse < tnew;
  endfunction

  function automatic bit m_busy();
    return E_mdStart || (done_at > cyc);
  endfunction

  function automatic int m_cnt();
    return (done_at > cyc) ? done_at - cyc : 0;
  endfunction

  function automatic bit m_stall();
    return hz(E_RegWrite, int'(E_RegSelected), int'(E_Tnew), int'(Drs), int'(DTuse_rs)) ||
           hz(M_RegWrite, int'(M_RegSelected), int'(M_Tnew), int'(Drs), int'(DTuse_rs)) ||
           hz(E_RegWrite, int'(E_RegSelected), int'(E_Tnew), int'(Drt), int'(DTuse_rt)) ||
           hz(M_RegWrite, int'(M_RegSelected), int'(M_Tnew), int'(Drt), int'(DTuse_rt)) ||
           (D_isMD && m_busy());
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done_at = cyc;
      m_scnt  = 0;
    end else begin
      if (m_stall()) m_scnt = m_scnt + 1;
      if (E_mdStart) done_at = cyc + (E_mdIsDiv ? DIV_LAT : MULT_LAT) + 1;
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("model stall",     32'(stall),   32'(m_stall()));
      check("model Ereset",    32'(Ereset),  32'(m_stall()));
      check("model md_busy",   32'(md_busy), 32'(m_busy()));
      check("model md_cnt",    32'(md_cnt),  32'(m_cnt()));
      check("model stall_cnt", stall_cnt,    32'(m_scnt));
    end
  end

  task automatic clear_inputs();
    Drs = '0; Drt = '0; DTuse_rs = 2'd3; DTuse_rt = 2'd3; D_isMD = 1'b0;
    E_RegWrite = 1'b0; E_RegSelected = '0; E_Tnew = '0;
    M_RegWrite = 1'b0; M_RegSelected = '0; M_Tnew = '0;
    E_mdStart = 1'b0; E_mdIsDiv = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    settle();
    check("reset md_cnt",    32'(md_cnt),  32'd0);
    check("reset stall_cnt", stall_cnt,    32'd0);
    check("reset md_busy",   32'(md_busy), 32'd0);
    check("reset stall",     32'(stall),   32'd0);
    step();
    reset = 1'b0;
    run_cmp = 1'b1;

    // Load-use through E, then the same register forwarded from M.
    clear_inputs();
    E_RegWrite = 1'b1; E_RegSelected = 5'd8; E_Tnew = 4'd2; Drs = 5'd8; DTuse_rs = 2'd1;
    settle();
    check("load-use stall",  32'(stall),  32'd1);
    check("load-use Ereset", 32'(Ereset), 32'd1);
    step();
    E_RegWrite = 1'b0; M_RegWrite = 1'b1; M_RegSelected = 5'd8; M_Tnew = 4'd1;
    settle();
    check("load-use resolved", 32'(stall), 32'd0);

    // $0, unused operand, non-writing producer.
    step();
    clear_inputs();
    E_RegWrite = 1'b1; E_RegSelected = 5'd0; E_Tnew = 4'd2; Drs = 5'd0; DTuse_rs = 2'd1;
    settle();
    check("zero reg", 32'(stall), 32'd0);
    step();
    E_RegSelected = 5'd8; Drs = 5'd8; DTuse_rs = 2'd3; E_Tnew = 4'd15;
    settle();
    check("tuse 3", 32'(stall), 32'd0);
    step();
    DTuse_rs = 2'd1; E_Tnew = 4'd2; E_RegWrite = 1'b0;
    settle();
    check("no regwrite", 32'(stall), 32'd0);

    // mult followed by mfhi held in D.
    step();
    clear_inputs();
    reset = 1'b1;
    settle();
    step();
    reset = 1'b0;
    E_mdStart = 1'b1; E_mdIsDiv = 1'b0; D_isMD = 1'b1;
    settle();
    check("mult t stall", 32'(stall), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      E_mdStart = 1'b0;
      settle();
      check("mult md_cnt", 32'(md_cnt), 32'(6 - k));
      check("mult stall",  32'(stall),  (k < 6) ? 32'd1 : 32'd0);
    end
    check("mult stall_cnt", stall_cnt, 32'd6);

    // div with no MDU user in D, then reset while in flight.
    step();
    clear_inputs();
    E_mdStart = 1'b1; E_mdIsDiv = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      settle();
      check("div md_busy", 32'(md_busy), (k <= 10) ? 32'd1 : 32'd0);
      check("div stall",   32'(stall),   32'd0);
      if (k == 1) check("div md_cnt start", 32'(md_cnt), 32'd10);
      step();
      E_mdStart = 1'b0;
    end
    E_mdStart = 1'b1; E_mdIsDiv = 1'b1;
    step();
    E_mdStart = 1'b0;
    for (int k = 0; k < 4; k++) step();
    settle();
    check("pre-reset md_cnt",    32'(md_cnt), 32'd6);
    check("pre-reset stall_cnt", stall_cnt,   32'd6);
    #1 reset = 1'b1;
    #1;
    check("async md_cnt",    32'(md_cnt),  32'd0);
    check("async md_busy",   32'(md_busy), 32'd0);
    check("async stall_cnt", stall_cnt,    32'd0);
    step();
    reset = 1'b0;

    // rt hazard through M with E clear.
    clear_inputs();
    M_RegWrite = 1'b1; M_RegSelected = 5'd31; M_Tnew = 4'd1; Drt = 5'd31; DTuse_rt = 2'd0;
    settle();
    check("rt via M", 32'(stall), 32'd1);
    step();
    DTuse_rt = 2'd1;
    settle();
    check("rt via M late use", 32'(stall), 32'd0);

    // Randomized traffic with a small register set to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = 1'b0;
      Drs = 5'($urandom_range(0, 3));
      Drt = 5'($urandom_range(0, 3));
      DTuse_rs = 2'($urandom_range(0, 3));
      DTuse_rt = 2'($urandom_range(0, 3));
      D_isMD = ($urandom_range(0, 2) == 0);
      E_RegWrite = $urandom_range(0, 1) == 1;
      E_RegSelected = 5'($urandom_range(0, 3));
      E_Tnew = 4'($urandom_range(0, 4));
      M_RegWrite = $urandom_range(0, 1) == 1;
      M_RegSelected = 5'($urandom_range(0, 3));
      M_Tnew = 4'($urandom_range(0, 4));
      E_mdStart = ($urandom_range(0, 9) == 0);
      E_mdIsDiv = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
      end
    end
    step();
    reset = 1'b0;
    clear_inputs();
    step();
    @(negedge clk);
    #1;
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
